// File: rtl/count_bcd_pkg.sv
// count_bcd_pkg: shared types and constants for the binary-to-BCD converter
package count_bcd_pkg;
  localparam int BCD_DIGIT_W = 4;
  typedef enum logic {IDLE, SHIFT} state_e;
  function automatic int min_digits(input int width);
    longint m;
    int d;
    m = (longint'(1) << width) - 1;
    d = 1;
    for (int i = 0; i < 20; i++)
      if (m >= 10) begin
        m = m / 10;
        d++;
      end
    return d;
  endfunction
endpackage

// File: rtl/bcd_digit_adj.sv
// bcd_digit_adj: double-dabble digit correction, adds 3 when the digit is 5 or more
module bcd_digit_adj
  import count_bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] a,
  output logic [BCD_DIGIT_W-1:0] y
);
  assign y = a >= BCD_DIGIT_W'(5) ? a + BCD_DIGIT_W'(3) : a;
endmodule

// File: rtl/count_bin2bcd.sv
// count_bin2bcd: iterative shift-and-add-3 binary to packed BCD converter, one bit per clock
module count_bin2bcd
  import count_bcd_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [WIDTH-1:0]              bin,
  output logic                          in_ready,
  output logic                          busy,
  output logic                          done,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd
);
  localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  localparam int BW = BCD_DIGIT_W * DIGITS;
  if (WIDTH < 1 || DIGITS < min_digits(WIDTH)) begin : g_bad_params
    $fatal(1, "count_bin2bcd: DIGITS too small for WIDTH or WIDTH < 1");
  end
  state_e            state, state_n;
  logic [WIDTH-1:0]  shift;
  logic [BW-1:0]     scratch, adj, scratch_n;
  logic [CW-1:0]     cnt;
  genvar i;
  for (i = 0; i < DIGITS; i++) begin : g_adj
    bcd_digit_adj u_adj (
      .a(scratch[BCD_DIGIT_W*i +: BCD_DIGIT_W]),
      .y(adj[BCD_DIGIT_W*i +: BCD_DIGIT_W])
    );
  end
  // adjusted digits shift left with the next binary MSB entering the units digit
  assign scratch_n = {adj[BW-2:0], shift[WIDTH-1]};
  assign in_ready  = state == IDLE;
  assign busy      = state == SHIFT;
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (in_valid ? SHIFT : IDLE) : (cnt == '0 ? IDLE : SHIFT);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      shift   <= '0;
      scratch <= '0;
      cnt     <= '0;
      bcd     <= '0;
      done    <= 1'b0;
    end else begin
      state <= state_n;
      done  <= 1'b0;
      if (state == IDLE) begin
        if (in_valid) begin
          shift   <= bin;
          scratch <= '0;
          cnt     <= CW'(WIDTH - 1);
        end
      end else begin
        scratch <= scratch_n;
        shift   <= shift << 1;
        cnt     <= cnt - 1'b1;
        if (cnt == '0) begin
          bcd  <= scratch_n;
          done <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_count_bin2bcd.sv
// tb_count_bin2bcd: scoreboard bench for the 8-bit converter plus a 16-bit instance
module tb_count_bin2bcd;
  logic        clk = 0, rst = 1;
  logic        in_valid = 0;
  logic [7:0]  bin = 0;
  logic        in_ready, busy, done;
  logic [11:0] bcd;
  logic        v16 = 0;
  logic [15:0] b16 = 0;
  logic        r16, busy16, done16;
  logic [19:0] bcd16;
  int checks = 0, errors = 0, ndone = 0;
  logic [31:0] q[$];

  count_bin2bcd #(.WIDTH(8), .DIGITS(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .bin(bin),
    .in_ready(in_ready), .busy(busy), .done(done), .bcd(bcd));
  count_bin2bcd #(.WIDTH(16), .DIGITS(5)) dut16 (
    .clk(clk), .rst(rst), .in_valid(v16), .bin(b16),
    .in_ready(r16), .busy(busy16), .done(done16), .bcd(bcd16));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] to_bcd(input int v);
    logic [31:0] r = 0;
    for (int k = 0; k < 8; k++) begin
      r = r | (32'(v % 10) << (4 * k));
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic digits_ok(input logic [11:0] b);
    for (int k = 0; k < 3; k++) if (b[4*k +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  always @(negedge clk) begin
    if (rst) q.delete();
    else begin
      if (done) begin
        ndone++;
        if (q.size() == 0) check("unexpected_done", 32'(done), 32'd0);
        else begin
          check("bcd", 32'(bcd), q.pop_front());
          check("digits", 32'(digits_ok(bcd)), 32'd1);
        end
      end
      if (in_valid && in_ready) q.push_back(to_bcd(int'(bin)));
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(output int lat, output int nb);
    lat = 0;
    nb  = 0;
    while (!done && lat < 30) begin
      if (busy && !in_ready) nb++;
      step();
      lat++;
    end
  endtask

  task automatic req(input logic [7:0] v, output int lat, output int nb);
    in_valid = 1;
    bin = v;
    step();
    in_valid = 0;
    wait_done(lat, nb);
  endtask

  initial begin
    int lat, nb, d0, w;
    logic [7:0] vals[5] = '{8'd0, 8'd9, 8'd10, 8'd99, 8'd100};
    repeat (3) step();
    rst = 0;
    step();
    check("rst_bcd", 32'(bcd), 0);
    check("rst_done", 32'(done), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_ready", 32'(in_ready), 1);

    d0 = ndone;
    req(8'd255, lat, nb);
    check("lat255", lat, 8);
    check("busy_cycles", nb, 8);
    check("bcd255", 32'(bcd), 32'h255);
    check("ready_at_done", 32'(in_ready), 1);
    step();
    check("done_pulse", 32'(done), 0);
    check("bcd_hold", 32'(bcd), 32'h255);
    check("done_count", ndone - d0, 1);

    foreach (vals[k]) begin
      req(vals[k], lat, nb);
      check("carry_lat", lat, 8);
      check("carry_bcd", 32'(bcd), to_bcd(int'(vals[k])));
    end

    in_valid = 1;
    bin = 8'd42;
    step();
    bin = 8'd7;
    w = 0;
    while (!in_ready && w < 30) begin step(); w++; end
    check("busy_wait", w, 8);
    check("bcd42", 32'(bcd), 32'h042);
    step();
    in_valid = 0;
    wait_done(lat, nb);
    check("lat7", lat, 8);
    check("bcd7", 32'(bcd), 32'h007);

    in_valid = 1;
    bin = 8'd200;
    step();
    in_valid = 0;
    repeat (3) step();
    d0 = ndone;
    rst = 1;
    step();
    rst = 0;
    check("abort_bcd", 32'(bcd), 0);
    check("abort_ready", 32'(in_ready), 1);
    check("abort_busy", 32'(busy), 0);
    repeat (10) step();
    check("abort_nodone", ndone - d0, 0);
    req(8'd200, lat, nb);
    check("bcd200", 32'(bcd), 32'h200);

    for (int c = 0; c < 256; c++) begin
      req(8'(c), lat, nb);
      if (lat != 8) check("sweep_lat", lat, 8);
    end

    v16 = 1;
    b16 = 16'd65535;
    step();
    v16 = 0;
    lat = 0;
    while (!done16 && lat < 40) begin step(); lat++; end
    check("lat16", lat, 16);
    check("bcd16", 32'(bcd16), 32'h65535);
    step();
    check("bcd16_hold", 32'(bcd16), 32'h65535);

    step();
    check("sb_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
